// File: rtl/matrix_add_seq_ctrl_if.sv
// Handshake and operand/result bus for the time-multiplexed 2x2 matrix adder.
interface matrix_add_seq_ctrl_if #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = IN_W + 1
) ();
  logic                 start;
  logic                 start_ready;
  logic [4*IN_W-1:0]    a_flat;
  logic [4*IN_W-1:0]    b_flat;
  logic [4*OUT_W-1:0]   c_flat;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           elem_idx;

  modport master (
    output start, a_flat, b_flat, out_ready,
    input  start_ready, c_flat, busy, out_valid, elem_idx
  );

  modport slave (
    input  start, a_flat, b_flat, out_ready,
    output start_ready, c_flat, busy, out_valid, elem_idx
  );
endinterface

// File: rtl/matrix_add_seq_ctrl.sv
// 2x2 matrix sum C = A + B computed one element per cycle through a single shared adder.
module matrix_add_seq_ctrl #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = IN_W + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  matrix_add_seq_ctrl_if.slave   bus
);

  localparam int unsigned N_EL = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [1:0]                r_idx, w_idx_nxt;
  logic [N_EL*IN_W-1:0]      r_a, w_a_nxt;
  logic [N_EL*IN_W-1:0]      r_b, w_b_nxt;
  logic [N_EL*OUT_W-1:0]     r_c, w_c_nxt;
  logic                      r_start_ready;
  logic                      r_busy;
  logic                      r_out_valid;

  logic [IN_W-1:0]           w_op_a;
  logic [IN_W-1:0]           w_op_b;
  logic [OUT_W-1:0]          w_sum;

  // The one adder: operands picked by the current element index.
  assign w_op_a = r_a[IN_W*r_idx +: IN_W];
  assign w_op_b = r_b[IN_W*r_idx +: IN_W];
  assign w_sum  = OUT_W'(w_op_a) + OUT_W'(w_op_b);

  // State, datapath and status flags; flags follow the next state so they stay pure register outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= 2'd0;
      r_a           <= '0;
      r_b           <= '0;
      r_c           <= '0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_a           <= w_a_nxt;
      r_b           <= w_b_nxt;
      r_c           <= w_c_nxt;
      r_start_ready <= (w_state_nxt == ST_IDLE);
      r_busy        <= (w_state_nxt == ST_ADD);
      r_out_valid   <= (w_state_nxt == ST_HOLD);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_c_nxt     = r_c;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_a_nxt     = bus.a_flat;
          w_b_nxt     = bus.b_flat;
          w_c_nxt     = '0;
          w_idx_nxt   = 2'd0;
          w_state_nxt = ST_ADD;
        end
      end
      ST_ADD: begin
        w_c_nxt[OUT_W*r_idx +: OUT_W] = w_sum;
        if (r_idx == 2'(N_EL - 1)) begin
          w_idx_nxt   = 2'd0;
          w_state_nxt = ST_HOLD;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  assign bus.start_ready = r_start_ready;
  assign bus.busy        = r_busy;
  assign bus.out_valid   = r_out_valid;
  assign bus.c_flat      = r_c;
  assign bus.elem_idx    = r_idx;

endmodule

// File: tb/tb_matrix_add_seq_ctrl.sv
// Directed bench for matrix_add_seq_ctrl: vector table plus handshake, backpressure and reset sequences.
module tb_matrix_add_seq_ctrl;

  localparam int unsigned IN_W  = 3;
  localparam int unsigned OUT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  matrix_add_seq_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  matrix_add_seq_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] c;
  } vec_t;

  vec_t vecs [6];

  // Element 0 (a11) sits in the least significant slot.
  function automatic logic [11:0] p3(input int e0, input int e1, input int e2, input int e3);
    return {3'(e3), 3'(e2), 3'(e1), 3'(e0)};
  endfunction

  function automatic logic [15:0] p4(input int e0, input int e1, input int e2, input int e3);
    return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && !bus.start_ready; k++) @(negedge clk);
    chk({tag, " wait_idle"}, 32'(bus.start_ready), 32'd1);
  endtask

  // One full operation with out_ready held high and noise on start/operands after acceptance.
  task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic [15:0] exp, input string tag);
    int nb;
    wait_idle(tag);
    bus.a_flat    = a;
    bus.b_flat    = b;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    chk({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    chk({tag, " c_cleared"}, 32'(bus.c_flat), 32'd0);
    bus.a_flat = 12'($urandom);
    bus.b_flat = 12'($urandom);
    bus.start  = 1'($urandom);
    nb = 1;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        nb++;
        bus.start = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    chk({tag, " busy_cycles"}, 32'(nb), 32'd4);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " c_flat"}, 32'(bus.c_flat), 32'(exp));
    @(negedge clk);
    chk({tag, " hold_one_cycle"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " back_to_idle"}, 32'(bus.start_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit seen1;
    bit prev_busy;
    logic [15:0] e1, e2;

    checks = 0;
    errors = 0;
    vecs[0] = '{p3(1,2,3,4), p3(4,3,2,1), p4(5,5,5,5)};
    vecs[1] = '{p3(7,7,7,7), p3(7,0,7,0), p4(14,7,14,7)};
    vecs[2] = '{p3(0,0,0,0), p3(0,0,0,0), p4(0,0,0,0)};
    vecs[3] = '{p3(0,1,0,1), p3(1,0,1,0), p4(1,1,1,1)};
    vecs[4] = '{p3(7,6,5,4), p3(1,2,3,7), p4(8,8,8,11)};
    vecs[5] = '{p3(3,0,7,2), p3(5,7,0,6), p4(8,7,7,8)};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_flat    = '0;
    bus.b_flat    = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst start_ready", 32'(bus.start_ready), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst c_flat", 32'(bus.c_flat), 32'd0);
    chk("rst elem_idx", 32'(bus.elem_idx), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, $sformatf("vec%0d", i));
    end

    // Backpressure: result frozen for 10 cycles under input noise.
    wait_idle("bp");
    bus.a_flat    = vecs[1].a;
    bus.b_flat    = vecs[1].b;
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
    chk("bp out_valid_rise", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      bus.a_flat = 12'($urandom);
      bus.b_flat = 12'($urandom);
      bus.start  = 1'($urandom);
      @(negedge clk);
      chk($sformatf("bp out_valid c%0d", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp c_flat c%0d", k), 32'(bus.c_flat), 32'(vecs[1].c));
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp release idle", 32'(bus.start_ready), 32'd1);
    chk("bp release valid", 32'(bus.out_valid), 32'd0);

    // Back-to-back with start held high: second accept six edges after the first.
    wait_idle("b2b");
    e1 = vecs[4].c;
    e2 = vecs[5].c;
    bus.a_flat    = vecs[4].a;
    bus.b_flat    = vecs[4].b;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    chk("b2b first accept", 32'(bus.busy), 32'd1);
    bus.a_flat = vecs[5].a;
    bus.b_flat = vecs[5].b;
    acc       = 0;
    seen1     = 1'b0;
    prev_busy = 1'b1;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid && !seen1) begin
        chk("b2b result1", 32'(bus.c_flat), 32'(e1));
        seen1 = 1'b1;
      end
      if (bus.busy && !prev_busy && acc == 0) begin
        acc       = k;
        bus.start = 1'b0;
      end
      if (acc > 0 && bus.out_valid) begin
        chk("b2b result2", 32'(bus.c_flat), 32'(e2));
        break;
      end
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    chk("b2b accept spacing", 32'(acc), 32'd6);

    // Reset after two elements are written discards the partial result.
    wait_idle("rst_add");
    bus.a_flat = p3(7,7,7,7);
    bus.b_flat = p3(7,7,7,7);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_add partial", 32'(bus.c_flat), 32'(p4(14,14,0,0)));
    chk("rst_add idx", 32'(bus.elem_idx), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_add start_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_add busy", 32'(bus.busy), 32'd0);
    chk("rst_add out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_add c_flat", 32'(bus.c_flat), 32'd0);
    chk("rst_add elem_idx", 32'(bus.elem_idx), 32'd0);
    run_op(p3(0,1,0,1), p3(1,0,1,0), p4(1,1,1,1), "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_add_seq_ctrl.md
Name: matrix_add_seq_ctrl

Overview:
- Sequencer that computes a 2x2 matrix sum C = A + B using one shared IN_W-bit adder, time-multiplexed over the four elements, one element per cycle.
- Operands are captured on a start/ready handshake. The result is held on a valid/ready output handshake.
- Sits in front of downstream matrix consumers in designs where four parallel adders are too costly.

Parameters:
- IN_W, 3, width of each operand element.
- OUT_W, IN_W+1, width of each result element; must be at least IN_W+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation; accepted only when start_ready=1.
- start_ready  out  1  high only in IDLE.
- a_flat  in  4*IN_W  matrix A, element i at [IN_W*i +: IN_W]; i=0 a11, 1 a12, 2 a21, 3 a22.
- b_flat  in  4*IN_W  matrix B, same packing as a_flat.
- c_flat  out  4*OUT_W  registered result, element i at [OUT_W*i +: OUT_W], same index order.
- busy  out  1  high in ADD state.
- out_valid  out  1  result valid; high in HOLD state.
- out_ready  in  1  consumer accepts result.
- elem_idx  out  2  element currently being added; debug only.

Behaviour:
- Clocking and reset:
  - Single clock domain, all state updates on the rising edge of clk.
  - rst is synchronous and active-high, and overrides every other input, including mid-operation.
  - After reset: state=IDLE, start_ready=1, busy=0, out_valid=0, elem_idx=0, c_flat=0, operand registers=0.
- States:
  - IDLE: start_ready=1. If start=1 at an edge, latch a_flat and b_flat into internal registers, clear c_flat to 0, set elem_idx=0, and go to ADD. Otherwise stay in IDLE.
  - ADD: busy=1, start_ready=0.
    - Each edge writes c[elem_idx] = zero-extended a_reg[elem_idx] + zero-extended b_reg[elem_idx], an unsigned OUT_W-bit result, then increments elem_idx.
    - The edge that writes elem_idx=3 moves to HOLD and wraps elem_idx to 0.
  - HOLD: out_valid=1, and c_flat is stable while in HOLD. If out_ready=1 at an edge, go to IDLE. Otherwise stay.
- Datapath and width:
  - Exactly one adder instance; the operands are selected by elem_idx.
  - Sum maximum is 2*(2^IN_W - 1), which fits OUT_W, so there is no overflow and no saturation.
- Latency:
  - Start accepted at edge T.
  - Elements written at edges T+1..T+4.
  - out_valid=1 from the cycle after T+4.
  - Minimum start-to-start interval is 6 cycles: T is the accept edge, T+5 is the earliest edge consuming out_ready, T+6 is the earliest next accept.
- Boundary conditions:
  - start while not IDLE: ignored, with no effect on operands or state.
  - Operand inputs changing after acceptance: no effect on the result.
  - out_ready while not HOLD: ignored.
  - out_ready held high continuously: HOLD lasts exactly 1 cycle.
  - start and out_ready both high in HOLD: only the HOLD→IDLE transition occurs; the start is not accepted until IDLE.
  - Reset during ADD or HOLD: immediate return to the reset values; the partial result is discarded.
- Outputs start_ready, busy and out_valid are decoded from registered state only; none has a combinational path from any input.

Test Plan:
- Reset check: assert rst for 2 cycles mid-ADD. Required: start_ready=1, busy=0, out_valid=0, c_flat=0 on the cycle after release.
- Basic operation: A={1,2,3,4}, B={4,3,2,1}, start pulsed one cycle, out_ready=1. Required: busy for 4 cycles, out_valid 1 cycle, c_flat={5,5,5,5}.
- Maximum values: A={7,7,7,7}, B={7,0,7,0}. Required: c_flat={14,7,14,7}, each element 4 bits with no truncation.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises, with a_flat/b_flat/start toggled randomly during that time. Required: out_valid and c_flat stable throughout. Then out_ready=1 for 1 cycle. Required: IDLE on the next cycle.
- Back-to-back: two ops with start held high, with out_ready=1 throughout. Required: second accept exactly 6 edges after the first, and both results correct.
- Reset mid-ADD: assert rst after 2 elements are written, then release, then run A={0,1,0,1}, B={1,0,1,0}. Required: c_flat={1,1,1,1}, with no residue from the aborted operation.
